// File: rtl/conversion_encoder.sv
// conversion_encoder: one-hot to binary index encoder with a small result FIFO.
// Accepts a one-hot word in octal (8-line), decimal (10-line) or hex (16-line)
// mode and queues {sel, err, code} results behind a valid/ready handshake.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     input handshake (in_ready = !rst && count < DEPTH)
//   in_onehot[15:0]       one-hot code, bits [W-1:0] meaningful for the mode
//   in_sel[1:0]           00 octal, 01 decimal, 10 hex, 11 reserved
//   out_valid/out_ready   output handshake on the FIFO head
//   out_code[3:0]         binary index of the set bit (0 when out_err=1)
//   out_sel[1:0]          mode echo for this result
//   out_err               input was not a legal one-hot code for its mode
//   err_count[CNT_W-1:0]  saturating illegal-input count (optional)
//
// Optional feature macro: CONVERSION_ENCODER_ERR_CNT_EN adds the CNT_W
// parameter, the err_count port and its counter.
module conversion_encoder #(
  parameter int unsigned DEPTH = 2
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
  ,
  parameter int unsigned CNT_W = 8
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_onehot,
  input  logic [1:0]        in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_code,
  output logic [1:0]        out_sel,
  output logic              out_err
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0]  err_count
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [1:0] sel;
    logic       err;
    logic [3:0] code;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic            push;
  logic            pop;
  logic            enc_err;
  logic [3:0]      enc_code;
  logic [4:0]      enc_ones;
  logic [4:0]      enc_lim;
  entry_t          wr_entry;

  // Combinational encode of the presented word.
  always_comb begin
    enc_err  = 1'b0;
    enc_code = 4'd0;
    enc_ones = 5'd0;
    enc_lim  = 5'd16;
    case (in_sel)
      2'b00:   enc_lim = 5'd8;
      2'b01:   enc_lim = 5'd10;
      2'b10:   enc_lim = 5'd16;
      default: enc_err = 1'b1;
    endcase
    for (int i = 0; i < 16; i++) begin
      if (in_onehot[i]) begin
        if (5'(i) >= enc_lim) enc_err = 1'b1;
        enc_ones = enc_ones + 5'd1;
        enc_code = 4'(i);
      end
    end
    if (enc_ones != 5'd1) enc_err = 1'b1;
    if (enc_err) enc_code = 4'd0;
  end

  assign wr_entry = '{sel: in_sel, err: enc_err, code: enc_code};

  // Ready is gated by rst so nothing is accepted during the reset cycle.
  assign in_ready  = !rst && (count_q < CW'(DEPTH));
  assign out_valid = (count_q != CW'(0));
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Pointer and occupancy next-state; pointers wrap since DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the idle head reads as all-zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  assign out_code = mem_q[rd_ptr_q].code;
  assign out_sel  = mem_q[rd_ptr_q].sel;
  assign out_err  = mem_q[rd_ptr_q].err;

`ifdef CONVERSION_ENCODER_ERR_CNT_EN
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Saturating count of accepted illegal words.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && enc_err && (err_cnt_q != {CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_conversion_encoder.sv
// Testbench for conversion_encoder: directed stimulus with a scoreboard queue
// of expected {sel, err, code} entries and an occupancy model for in_ready.
module tb_conversion_encoder;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_onehot = 16'd0;
  logic [1:0]  in_sel = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_code;
  logic [1:0]  out_sel;
  logic        out_err;

  int errors = 0;
  int checks = 0;
  bit inited = 1'b0;
  logic [6:0] sb[$];

`ifdef CONVERSION_ENCODER_ERR_CNT_EN
  logic [7:0] err_count;
  logic [1:0] err_count2;
  logic       in_ready2, out_valid2, out_err2;
  logic [3:0] out_code2;
  logic [1:0] out_sel2;
  int errm = 0;
  int errm2 = 0;
`endif

  conversion_encoder #(
    .DEPTH(DEPTH)
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
    , .CNT_W(8)
`endif
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_onehot (in_onehot),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_code  (out_code),
    .out_sel   (out_sel),
    .out_err   (out_err)
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
    , .err_count (err_count)
`endif
  );

`ifdef CONVERSION_ENCODER_ERR_CNT_EN
  conversion_encoder #(.DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready2),
    .in_onehot (in_onehot),
    .in_sel    (in_sel),
    .out_valid (out_valid2),
    .out_ready (out_ready),
    .out_code  (out_code2),
    .out_sel   (out_sel2),
    .out_err   (out_err2),
    .err_count (err_count2)
  );
`endif

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference encode: {sel, err, code}.
  function automatic logic [6:0] ref_enc(input logic [1:0] s, input logic [15:0] v);
    int w;
    logic [15:0] hi;
    case (s)
      2'b00:   w = 8;
      2'b01:   w = 10;
      2'b10:   w = 16;
      default: w = 0;
    endcase
    if (w == 0) return {s, 1'b1, 4'd0};
    hi = (w == 16) ? 16'd0 : (v >> w);
    if (hi != 16'd0 || $countones(v) != 1) return {s, 1'b1, 4'd0};
    for (int i = 0; i < 16; i++)
      if (v == (16'd1 << i)) return {s, 1'b0, 4'(i)};
    return {s, 1'b1, 4'd0};
  endfunction

  // One clock: check outputs against the model before the edge, then advance it.
  task automatic tick(output bit acc);
    bit exp_rdy, exp_vld;
    logic [6:0] e;
    #1;
    exp_rdy = !rst && (sb.size() < DEPTH);
    exp_vld = (sb.size() != 0);
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    if (inited) begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_vld});
      if (exp_vld) begin
        chk("out_code", {28'd0, out_code}, {28'd0, sb[0][3:0]});
        chk("out_err",  {31'd0, out_err},  {31'd0, sb[0][4]});
        chk("out_sel",  {30'd0, out_sel},  {30'd0, sb[0][6:5]});
      end
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
      chk("err_count", {24'd0, err_count}, errm);
`endif
    end
    acc = in_valid && exp_rdy;
    @(posedge clk);
    if (rst) begin
      sb.delete();
      inited = 1'b1;
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
      errm = 0;
      errm2 = 0;
`endif
    end else begin
      if (exp_vld && out_ready) void'(sb.pop_front());
      if (acc) begin
        e = ref_enc(in_sel, in_onehot);
        sb.push_back(e);
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
        if (e[4] && errm < 255) errm++;
        if (e[4] && errm2 < 3) errm2++;
`endif
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input logic [1:0] s, input logic [15:0] v);
    bit acc;
    int n;
    in_sel = s;
    in_onehot = v;
    in_valid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      tick(acc);
      n++;
    end
    chk("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  initial begin
    bit acc;
    int w;

    // Reset for two cycles with a word presented.
    rst = 1'b1;
    in_valid = 1'b1;
    in_onehot = 16'h0001;
    in_sel = 2'b10;
    idle(2);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_out_code", {28'd0, out_code}, 32'd0);
    chk("rst_out_err",  {31'd0, out_err},  32'd0);
    chk("rst_out_sel",  {30'd0, out_sel},  32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    idle(1);

    // Legal top-index codes in each mode.
    out_ready = 1'b1;
    send(2'b00, 16'h0080);
    #1;
    chk("oct7_code", {28'd0, out_code}, 32'd7);
    chk("oct7_err",  {31'd0, out_err},  32'd0);
    send(2'b01, 16'h0200);
    #1;
    chk("dec9_code", {28'd0, out_code}, 32'd9);
    send(2'b10, 16'h8000);
    #1;
    chk("hex15_code", {28'd0, out_code}, 32'd15);
    chk("hex15_sel",  {30'd0, out_sel},  32'd2);
    idle(2);

    // Single-bit sweeps, back-to-back (hex sweep is the 16-word stream).
    for (int m = 0; m < 3; m++) begin
      w = (m == 0) ? 8 : (m == 1) ? 10 : 16;
      for (int i = 0; i < w; i++) send(2'(m), 16'd1 << i);
      idle(2);
    end

    // Illegal codes.
    send(2'b00, 16'h0100);
    #1;
    chk("ill_oob_err",  {31'd0, out_err},  32'd1);
    chk("ill_oob_code", {28'd0, out_code}, 32'd0);
    send(2'b10, 16'h0000);
    send(2'b10, 16'h0011);
    send(2'b11, 16'h0001);
    idle(2);
`ifdef CONVERSION_ENCODER_ERR_CNT_EN
    chk("err_count_4", {24'd0, err_count}, 32'd4);
`endif

    // Backpressure: fill, hold a third word, then release.
    out_ready = 1'b0;
    send(2'b10, 16'h0001);
    send(2'b10, 16'h0004);
    in_sel = 2'b10;
    in_onehot = 16'h0010;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("bp_not_accepted", {31'd0, acc}, 32'd0);
    end
    #1;
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_code", {28'd0, out_code}, 32'd0);
    out_ready = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) tick(acc);
    chk("bp_third_accept", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
    idle(3);

    // Reset with the FIFO full: nothing stale may emerge.
    out_ready = 1'b0;
    send(2'b01, 16'h0001);
    send(2'b01, 16'h0002);
    in_valid = 1'b1;
    in_onehot = 16'h0004;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_code",  {28'd0, out_code},  32'd0);
    idle(4);

`ifdef CONVERSION_ENCODER_ERR_CNT_EN
    // Five illegal words saturate the 2-bit counter.
    for (int i = 0; i < 5; i++) send(2'b11, 16'h0001);
    idle(2);
    chk("err_count2_sat", {30'd0, err_count2}, 32'd3);
    chk("err_count2_model", {30'd0, err_count2}, errm2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
